// File: rtl/multi.sv
// multi: sequential shift-add unsigned multiplier.
// Takes two WIDTH-bit operands on a start pulse and retires one multiplier bit
// per clock. The 2*WIDTH-bit product is presented with a one-cycle done strobe.
// Optional feature: define MULTI_ZERO_SKIP_EN to finish in one clock when
// either operand is zero.
module multi #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcandReg;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] stepAcc;

    // One shift-add iteration. The sum keeps WIDTH+1 bits so the carry out of
    // the high half lands in the top product bit after the right shift.
    function automatic logic [2*WIDTH-1:0] shiftAddStep(
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] mcand
    );
        logic [WIDTH:0] sum;
        sum = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
        return {sum, lo[WIDTH-1:1]};
    endfunction

    // Next accumulator value for the current RUN iteration.
    always_comb begin
        stepAcc = shiftAddStep(accHi, accLo, mcandReg);
    end

    // Control FSM with registered busy/done/product and the iterating datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            mcandReg <= '0;
            accHi    <= '0;
            accLo    <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    // start and operand inputs are deliberately ignored here.
                    accHi <= stepAcc[2*WIDTH-1:WIDTH];
                    accLo <= stepAcc[WIDTH-1:0];
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= stepAcc;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE lasts one cycle.
                    if (start) begin
`ifdef MULTI_ZERO_SKIP_EN
                        if ((multiplicand == '0) || (multiplier == '0)) begin
                            // Result is known to be zero: skip the iterations.
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            product  <= '0;
                            mcandReg <= multiplicand;
                            accHi    <= '0;
                            accLo    <= '0;
                            cnt      <= '0;
                        end else
`endif
                        begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            mcandReg <= multiplicand;
                            accHi    <= '0;
                            accLo    <= multiplier;
                            cnt      <= CNT_W'(WIDTH);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
